// File: rtl/cameralink_pkg.sv
// Shared types and constants for the CameraLink frame capture sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a. Buffer entries are laid out as {sof, eof, data}.
package cameralink_pkg;

  localparam int DATA_W_DEF = 48;  // 4 px x 12 b per PHY word
  localparam int CNT_W_DEF  = 24;  // frame word counter width
  localparam int FLAG_W     = 2;   // sof + eof bits above the pixel data

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_DRAIN
  } cap_state_t;

  // Upper bits of a buffer entry: {sof, eof}
  function automatic logic [FLAG_W-1:0] entry_flags(input logic sof, input logic eof);
    return {sof, eof};
  endfunction

endpackage

// File: rtl/cameralink_capture_ctrl_if.sv
// Ready/valid pixel-word stream with frame markers (tuser = SOF, tlast = EOF).
// Latency: n/a (wires only).
// Backpressure: source holds tdata/tuser/tlast stable while tvalid && !tready.
interface cameralink_capture_ctrl_if
  import cameralink_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) ();
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tuser;
  logic              tlast;

  modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/cl_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with synchronous flush.
// Latency: a written word is visible on rd_dat the cycle after the write.
// Backpressure: write while full is refused unless a read happens in the same cycle.
// Ports: clk/rst_n (sync, active-low), flush, wr_en/wr_dat/full, rd_en/rd_dat/empty.
module cl_sync_fifo
  import cameralink_pkg::*;
#(
  parameter int WIDTH = DATA_W_DEF + FLAG_W,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_dat,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_dat,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr_ok;
  logic             rd_ok;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign rd_ok = rd_en && !empty && !flush;
  // A full buffer still takes a write when the head leaves in the same cycle.
  assign wr_ok = wr_en && (!full || rd_ok) && !flush;
  // Zero when empty so the stream outputs read 0 out of reset.
  assign rd_dat = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
    end
  end
endmodule

// File: rtl/cameralink_capture_ctrl.sv
// Frame capture sequencer: arms on command, aligns to PHY frame start, frames
// cfg_frame_words words onto a ready/valid stream with SOF/EOF, counts frames and
// flags short/long/overflow errors. Latency: pix word on m.tdata 1 cycle later when
// the buffer is empty. Backpressure: none upstream; full buffer drops and flags.
// Ports: sys_clk/sys_rst_n, pix_* (PHY side), cfg_*, ctrl_*, m (stream master),
// busy/frame_done/frame_count/err_* status.
module cameralink_capture_ctrl
  import cameralink_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [DATA_W-1:0] pix_data,
  input  logic              pix_vld,
  input  logic              pix_new_frame,
  input  logic [CNT_W-1:0]  cfg_frame_words,
  input  logic              cfg_continuous,
  input  logic              ctrl_start,
  input  logic              ctrl_stop,
  input  logic              ctrl_abort,
  input  logic              ctrl_clr_err,
  cameralink_capture_ctrl_if.master m,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       frame_count,
  output logic              err_short,
  output logic              err_long,
  output logic              err_overflow
);
  cap_state_t       state;
  cap_state_t       rearm_state;
  logic [CNT_W-1:0] word_cnt;
  logic [CNT_W-1:0] frame_words;
  logic [CNT_W-1:0] cur_cnt;
  logic [CNT_W-1:0] cur_words;
  logic             stop_pending;
  logic             post_frame;
  logic             act;
  logic             start_frame;
  logic             take;
  logic             is_eof;
  logic             pop;
  logic             push;
  logic             eof_hs;
  logic             short_set;
  logic             long_set;
  logic             ovf_set;
  logic             fifo_full;
  logic             fifo_empty;
  logic [DATA_W+FLAG_W-1:0] fifo_rd;

  always_comb begin
    // Abort, or a stop while armed, suppresses any capture this cycle.
    act         = !ctrl_abort && !((state == ST_ARMED) && ctrl_stop);
    start_frame = act && pix_new_frame && ((state == ST_ARMED) || (state == ST_CAPTURE));
    // A frame start restarts counting this very cycle so a same-cycle word is word 0.
    cur_words   = start_frame ? cfg_frame_words : frame_words;
    cur_cnt     = start_frame ? '0 : word_cnt;
    is_eof      = (cur_cnt == cur_words - CNT_W'(1));
    take        = act && pix_vld && (start_frame || (state == ST_CAPTURE));
    pop         = m.tvalid && m.tready;
    push        = take && (!fifo_full || pop);
    ovf_set     = take && fifo_full && !pop;
    eof_hs      = pop && m.tlast;
    short_set   = act && pix_new_frame && (state == ST_CAPTURE);
    long_set    = pix_vld && post_frame && !pix_new_frame;
    rearm_state = (cfg_continuous && !stop_pending && !ctrl_stop) ? ST_ARMED : ST_IDLE;
  end

  cl_sync_fifo #(
    .WIDTH (DATA_W + FLAG_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (sys_clk),
    .rst_n  (sys_rst_n),
    .flush  (ctrl_abort),
    .wr_en  (push),
    .wr_dat ({entry_flags(cur_cnt == '0, is_eof), pix_data}),
    .full   (fifo_full),
    .rd_en  (pop),
    .rd_dat (fifo_rd),
    .empty  (fifo_empty)
  );

  assign m.tvalid                  = !fifo_empty;
  assign {m.tuser, m.tlast, m.tdata} = fifo_rd;
  assign busy                      = (state != ST_IDLE);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state        <= ST_IDLE;
      word_cnt     <= '0;
      frame_words  <= '0;
      stop_pending <= 1'b0;
      post_frame   <= 1'b0;
      frame_done   <= 1'b0;
      frame_count  <= '0;
      err_short    <= 1'b0;
      err_long     <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      frame_done   <= 1'b0;
      // Clear then set: a new error in the clear cycle survives.
      err_short    <= (err_short    & ~ctrl_clr_err) | short_set;
      err_long     <= (err_long     & ~ctrl_clr_err) | long_set;
      err_overflow <= (err_overflow & ~ctrl_clr_err) | ovf_set;

      // post_frame also covers a dropped eof so framing stays aligned.
      if (take && is_eof)     post_frame <= 1'b1;
      else if (pix_new_frame) post_frame <= 1'b0;

      if (start_frame) frame_words <= cfg_frame_words;
      if (take)             word_cnt <= cur_cnt + CNT_W'(1);
      else if (start_frame) word_cnt <= '0;

      if (ctrl_abort) begin
        state        <= ST_IDLE;
        stop_pending <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (ctrl_start && !ctrl_stop) state <= ST_ARMED;
          end
          ST_ARMED, ST_CAPTURE: begin
            if ((state == ST_ARMED) && ctrl_stop) begin
              state <= ST_IDLE;
            end else begin
              if (ctrl_stop) stop_pending <= 1'b1;
              if (take && is_eof) begin
                if (push) begin
                  state <= ST_DRAIN;
                end else begin
                  // eof lost to overflow: nothing left to drain for this frame
                  state <= rearm_state;
                  if (rearm_state == ST_IDLE) stop_pending <= 1'b0;
                end
              end else if (start_frame) begin
                state <= ST_CAPTURE;
              end
            end
          end
          ST_DRAIN: begin
            if (ctrl_stop) stop_pending <= 1'b1;
            if (eof_hs) begin
              state       <= rearm_state;
              frame_done  <= 1'b1;
              frame_count <= frame_count + 16'd1;
              if (rearm_state == ST_IDLE) stop_pending <= 1'b0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/cameralink_capture_ctrl.md
Name: cameralink_capture_ctrl

Overview:
Frame capture sequencer downstream of the medium-config CameraLink PHY, in the sys_clk domain.
- Consumes the PHY's 48-bit 4-pixel words (pixel_data_o/pixel_vld/new_frame).
- Arms on software command and aligns to the frame start.
- Frames exactly cfg_frame_words words per frame onto a ready/valid stream with SOF/EOF markers, through a small buffer.
- Reports frame count plus short-frame, long-frame and overflow errors. The PHY has no backpressure, so buffer overflow drops data and flags it.

Parameters:
DATA_W, 48, pixel word width (4 px x 12 b)
FIFO_DEPTH, 8, output buffer depth in words, power of 2, >=2
CNT_W, 24, width of the frame word counter and cfg_frame_words

Ports:
sys_clk  in  1  single clock for all logic
sys_rst_n  in  1  synchronous reset, active-low
pix_data  in  DATA_W  PHY pixel word
pix_vld  in  1  PHY word strobe, no backpressure
pix_new_frame  in  1  1-cycle frame-start pulse from PHY
cfg_frame_words  in  CNT_W  words per frame; sampled at frame start; must be >=1
cfg_continuous  in  1  1: re-arm after each frame; 0: single shot
ctrl_start  in  1  pulse: IDLE->ARMED
ctrl_stop  in  1  pulse: finish current frame, then IDLE
ctrl_abort  in  1  pulse: immediate IDLE, buffer flushed
ctrl_clr_err  in  1  pulse: clear sticky errors
m_tdata  out  DATA_W  output word
m_tvalid  out  1  output valid
m_tready  in  1  downstream ready
m_tuser  out  1  SOF, first word of frame
m_tlast  out  1  EOF, word cfg_frame_words-1
busy  out  1  state != IDLE
frame_done  out  1  1-cycle pulse when a frame's last word is consumed downstream
frame_count  out  16  completed frames since reset; wraps
err_short  out  1  sticky: new_frame before last word
err_long  out  1  sticky: pix_vld after last word, before next new_frame
err_overflow  out  1  sticky: pix_vld dropped because buffer full

Behaviour:
- Reset (sys_rst_n=0 at a clock edge):
  - state IDLE, buffer empty.
  - All outputs 0: m_tvalid, m_tuser, m_tlast, busy, frame_done, frame_count, errors. m_tdata is 0.
- States:
  - IDLE:
    - ctrl_start -> ARMED.
    - pix_vld is ignored.
  - ARMED:
    - Waits for pix_new_frame, then -> CAPTURE, with word_cnt=0 and frame_words latched from cfg_frame_words.
    - A pix_vld in the same cycle as pix_new_frame is accepted as word 0.
    - Other pix_vld is dropped.
  - CAPTURE:
    - Each pix_vld pushes {data, sof=(word_cnt==0), eof=(word_cnt==frame_words-1)} and increments word_cnt.
    - When the eof word is pushed -> DRAIN.
  - DRAIN:
    - Waits until the eof word handshakes (m_tvalid&m_tready&m_tlast).
    - That cycle+1: frame_done=1 and frame_count+1.
    - Next state is ARMED if cfg_continuous=1 and no stop is pending, else IDLE.
- ctrl_stop:
  - In ARMED or IDLE: -> IDLE next cycle.
  - In CAPTURE or DRAIN: sets stop_pending and the frame completes normally. stop_pending clears on entry to IDLE.
- ctrl_abort:
  - Any state -> IDLE next cycle.
  - Buffer flushed, m_tvalid=0 next cycle, no frame_done.
  - Has priority over all other controls.
- Short frame: pix_new_frame in CAPTURE with no eof pushed.
  - Sets err_short.
  - Relatch frame_words, word_cnt=0; a same-cycle pix_vld becomes word 0 (sof=1).
  - No frame_done and no count increment for the truncated frame.
- Long frame: post_frame flag is set when eof is pushed and cleared on pix_new_frame. pix_vld while post_frame=1 is dropped and sets err_long.
- Overflow: pix_vld in CAPTURE with buffer full.
  - Word dropped, err_overflow set.
  - word_cnt still increments so framing stays aligned.
  - If the dropped word is eof, -> ARMED/IDLE directly per continuous/stop rules, with no frame_done.
- Buffer push and pop in the same cycle while full: the push is accepted.
- Latency: pix_vld word appears on m_tdata 1 cycle later if the buffer was empty. m_* are registered outputs from the buffer head.
- Output stream rules:
  - m_tvalid stays high and m_tdata/m_tuser/m_tlast stay stable until handshake.
  - m_tlast and m_tuser are both 1 when frame_words=1.
- Sticky errors:
  - ctrl_clr_err clears them; a set in the same cycle wins.
  - Errors persist across start/stop/abort.

Decomposition:
- Package cameralink_pkg: state enum (IDLE, ARMED, CAPTURE, DRAIN), DATA_W and CNT_W default constants, and the buffer entry layout {sof, eof, data}.
- Sub-module cl_sync_fifo:
  - Single-clock FIFO, width DATA_W+2, depth FIFO_DEPTH.
  - Signals: full, empty, first-word-fall-through output, synchronous flush.

Test Plan:
- Basic single shot:
  - Stimulus: cfg_frame_words=4, cfg_continuous=0; start; new_frame; 4 pix_vld with data 1..4; m_tready=1.
  - Response: 4 beats with tuser on 1 and tlast on 4; frame_done once; frame_count=1; busy drops; no errors.
- Continuous with stop:
  - Stimulus: frame_words=3, three frames; ctrl_stop during frame 2.
  - Response: frames 1 and 2 are output, frame 3 is ignored; frame_count=2; state IDLE.
- Short/long frames:
  - Stimulus: frame_words=5; new_frame after 3 words, then 5 words.
  - Response: err_short=1; second frame is output with tuser on its first word and tlast on its 5th; frame_count=1.
  - Stimulus: then 2 extra pix_vld.
  - Response: err_long=1, extras are not output.
- Backpressure overflow:
  - Stimulus: FIFO_DEPTH=8, m_tready=0, 10 pix_vld.
  - Response: 8 words buffered, err_overflow=1. After m_tready=1, 8 words drain intact.
- Abort/reset mid-frame:
  - Stimulus: ctrl_abort after 2 of 4 words.
  - Response: m_tvalid=0 the next cycle, IDLE, no frame_done.
  - Stimulus: sys_rst_n=0 mid-stream, then ctrl_clr_err together with a new error.
  - Response: reset zeroes every output; the error stays set.
- frame_words=1 plus simultaneous new_frame and pix_vld:
  - Response: a single beat with tuser=tlast=1; frame_count+1.
